// File: rtl/dm_arbiter_if.sv
// Bus bundle between the CPU/checker requesters, the dm_arbiter and the dm memory.
// slave = arbiter side, master = requester/memory environment side.
interface dm_arbiter_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              chk_req;
    logic [ADDR_W-1:0] chk_addr;
    logic              chk_gnt;
    logic              chk_rvalid;
    logic [DATA_W-1:0] chk_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, chk_req, chk_addr, mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, chk_gnt, chk_rvalid, chk_rdata,
               mem_addr, mem_rd, mem_wr, mem_wdata, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, chk_req, chk_addr, mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, chk_gnt, chk_rvalid, chk_rdata,
               mem_addr, mem_rd, mem_wr, mem_wdata, busy
    );
endinterface

// File: rtl/dm_arbiter.sv
// Shares the single-ported dm between the CPU load/store port and the checker read port.
// Round-robin by default; define DM_ARB_CPU_PRIO_EN for CPU priority with a starvation guard.
module dm_arbiter #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input logic         clk,
    input logic         reset,
    dm_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;

    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("dm_arbiter: MAX_WAIT must be at least 1");
    end

    logic [1:0]        state_q, state_d;
    logic              last_chk_q, last_chk_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              chk_gnt_q, chk_gnt_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic              chk_rvalid_q, chk_rvalid_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] chk_rdata_q, chk_rdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              cpu_win, chk_win;

`ifdef DM_ARB_CPU_PRIO_EN
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    // CPU wins conflicts unless the checker has already lost MAX_WAIT times in a row.
    assign chk_win = bus.chk_req && (!bus.cpu_req || (wait_cnt_q == WAIT_W'(MAX_WAIT)));
`else
    assign chk_win = bus.chk_req && (!bus.cpu_req || !last_chk_q);
`endif
    assign cpu_win = bus.cpu_req && !chk_win;

    always_comb begin
        state_d      = state_q;
        last_chk_d   = last_chk_q;
        cpu_gnt_d    = 1'b0;
        chk_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        chk_rvalid_d = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        chk_rdata_d  = chk_rdata_q;
        mem_addr_d   = mem_addr_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
`ifdef DM_ARB_CPU_PRIO_EN
        wait_cnt_d   = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_win) begin
                    state_d     = ACCESS;
                    last_chk_d  = 1'b0;
                    cpu_gnt_d   = 1'b1;
                    mem_addr_d  = bus.cpu_addr;
                    mem_rd_d    = !bus.cpu_we;
                    mem_wr_d    = bus.cpu_we;
                    mem_wdata_d = bus.cpu_we ? bus.cpu_wdata : '0;
                end else if (chk_win) begin
                    state_d     = ACCESS;
                    last_chk_d  = 1'b1;
                    chk_gnt_d   = 1'b1;
                    mem_addr_d  = bus.chk_addr;
                    mem_rd_d    = 1'b1;
                    mem_wdata_d = '0;
                end
`ifdef DM_ARB_CPU_PRIO_EN
                if (chk_win) begin
                    wait_cnt_d = '0;
                end else if (cpu_win && bus.chk_req) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
`endif
            end
            ACCESS: state_d = mem_wr_q ? IDLE : WAIT;
            WAIT: begin
                // The winner of the grant just completed is still recorded in last_chk_q.
                if (last_chk_q) begin
                    chk_rdata_d  = bus.mem_rdata;
                    chk_rvalid_d = 1'b1;
                end else begin
                    cpu_rdata_d  = bus.mem_rdata;
                    cpu_rvalid_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_chk_q   <= 1'b1;
            cpu_gnt_q    <= 1'b0;
            chk_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            chk_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            chk_rdata_q  <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
`ifdef DM_ARB_CPU_PRIO_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_chk_q   <= last_chk_d;
            cpu_gnt_q    <= cpu_gnt_d;
            chk_gnt_q    <= chk_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            chk_rvalid_q <= chk_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            chk_rdata_q  <= chk_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
`ifdef DM_ARB_CPU_PRIO_EN
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.chk_gnt    = chk_gnt_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.chk_rvalid = chk_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.chk_rdata  = chk_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: timeline reference model checked every cycle, directed scenarios
// pinned with literal expectations, then randomized two-port traffic.
module tb_dm_arbiter;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 32;
`ifdef DM_ARB_CPU_PRIO_EN
    localparam int unsigned MAX_WAIT = 2;
`else
    localparam int unsigned MAX_WAIT = 4;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // dm: synchronous 1-cycle read memory
    logic [31:0] dm [128];
    bit dm_init = 1'b0;
    always @(posedge clk) begin
        if (!dm_init) begin
            for (int i = 0; i < 128; i++) dm[i] <= init_word(i);
            dm_init <= 1'b1;
        end else if (bus.mem_wr) begin
            dm[bus.mem_addr] <= bus.mem_wdata;
        end
        if (bus.mem_rd) bus.mem_rdata <= dm[bus.mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: each grant decided in an idle cycle t books expected events on a timeline.
    typedef struct {
        bit          cg;
        bit          kg;
        bit          rd;
        bit          wr;
        bit          bsy;
        bit          crv;
        bit          krv;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } slot_t;

    slot_t       sched [8];
    logic [31:0] mmem [128];
    bit          mmem_init = 1'b0;
    int          free_cyc = 0;
    bit          m_last_chk = 1'b1;
    logic [31:0] e_cpu_rdata = '0;
    logic [31:0] e_chk_rdata = '0;
`ifdef DM_ARB_CPU_PRIO_EN
    int          m_wait = 0;
`endif

    // Observations for the directed literal checks
    int          cpu_gnt_cyc, chk_gnt_cyc, cpu_rv_cyc, chk_rv_cyc;
    int          wr_pulses = 0, cpu_rv_count = 0;
    logic [6:0]  cpu_gnt_addr;
    bit          cpu_gnt_rd;
    logic [31:0] last_cpu_rd, last_chk_rd;
    bit          winners[$];

    always @(negedge clk) begin : model
        slot_t e;
        bit    win_chk, rd_op;
        logic [6:0] a;
        if (!mmem_init) begin
            for (int i = 0; i < 128; i++) mmem[i] = init_word(i);
            mmem_init = 1'b1;
        end
        if (!reset) begin
            for (int i = 0; i < 8; i++) sched[i] = '{default: 0};
            e_cpu_rdata = '0;
            e_chk_rdata = '0;
            m_last_chk  = 1'b1;
            free_cyc    = cyc;
`ifdef DM_ARB_CPU_PRIO_EN
            m_wait      = 0;
`endif
        end
        e = sched[cyc % 8];
        if (e.crv) e_cpu_rdata = e.rdata;
        if (e.krv) e_chk_rdata = e.rdata;
        check("cpu_gnt", 32'(bus.cpu_gnt), 32'(e.cg));
        check("chk_gnt", 32'(bus.chk_gnt), 32'(e.kg));
        check("mem_rd", 32'(bus.mem_rd), 32'(e.rd));
        check("mem_wr", 32'(bus.mem_wr), 32'(e.wr));
        check("busy", 32'(bus.busy), 32'(e.bsy));
        check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(e.crv));
        check("chk_rvalid", 32'(bus.chk_rvalid), 32'(e.krv));
        check("cpu_rdata", bus.cpu_rdata, e_cpu_rdata);
        check("chk_rdata", bus.chk_rdata, e_chk_rdata);
        if (e.rd || e.wr) begin
            check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
            check("mem_wdata", bus.mem_wdata, e.wdata);
        end
        if (bus.cpu_gnt) begin
            cpu_gnt_cyc  = cyc;
            cpu_gnt_addr = bus.mem_addr;
            cpu_gnt_rd   = bus.mem_rd;
            winners.push_back(1'b0);
        end
        if (bus.chk_gnt) begin
            chk_gnt_cyc = cyc;
            winners.push_back(1'b1);
        end
        if (bus.mem_wr) wr_pulses++;
        if (bus.cpu_rvalid) begin
            cpu_rv_cyc  = cyc;
            last_cpu_rd = bus.cpu_rdata;
            cpu_rv_count++;
        end
        if (bus.chk_rvalid) begin
            chk_rv_cyc  = cyc;
            last_chk_rd = bus.chk_rdata;
        end
        sched[cyc % 8] = '{default: 0};

        if (reset && cyc >= free_cyc && (bus.cpu_req || bus.chk_req)) begin
            if (bus.cpu_req && bus.chk_req) begin
`ifdef DM_ARB_CPU_PRIO_EN
                win_chk = (m_wait >= int'(MAX_WAIT));
`else
                win_chk = (m_last_chk == 1'b0);
`endif
            end else begin
                win_chk = bus.chk_req;
            end
`ifdef DM_ARB_CPU_PRIO_EN
            if (win_chk) m_wait = 0;
            else if (bus.chk_req) m_wait++;
`endif
            m_last_chk = win_chk;
            rd_op = win_chk || !bus.cpu_we;
            a = win_chk ? bus.chk_addr : bus.cpu_addr;
            sched[(cyc + 1) % 8].cg    = !win_chk;
            sched[(cyc + 1) % 8].kg    = win_chk;
            sched[(cyc + 1) % 8].rd    = rd_op;
            sched[(cyc + 1) % 8].wr    = !rd_op;
            sched[(cyc + 1) % 8].bsy   = 1'b1;
            sched[(cyc + 1) % 8].addr  = a;
            sched[(cyc + 1) % 8].wdata = rd_op ? 32'h0 : bus.cpu_wdata;
            if (rd_op) begin
                sched[(cyc + 2) % 8].bsy   = 1'b1;
                sched[(cyc + 3) % 8].crv   = !win_chk;
                sched[(cyc + 3) % 8].krv   = win_chk;
                sched[(cyc + 3) % 8].rdata = mmem[a];
                free_cyc = cyc + 3;
            end else begin
                mmem[a]  = bus.cpu_wdata;
                free_cyc = cyc + 2;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (5) tick();
    endtask

    task automatic cpu_issue(input bit we, input logic [6:0] a, input logic [31:0] d);
        tick();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
    endtask

    task automatic wait_gnt(input bit for_chk, input string name);
        int n = 0;
        while (!(for_chk ? bus.chk_gnt : bus.cpu_gnt) && n < 20) begin
            tick();
            n++;
        end
        check({name, " grant timeout"}, 32'(n < 20), 32'd1);
        if (for_chk) bus.chk_req = 1'b0;
        else bus.cpu_req = 1'b0;
    endtask

    task automatic reset_pulse();
        tick();
        bus.cpu_req = 1'b0;
        bus.chk_req = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int n, wp, rc, got;
        bit exp_order [6];
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 7'h05;
        bus.cpu_wdata = '0;
        bus.chk_req   = 1'b1;
        bus.chk_addr  = 7'h06;

        // Reset held with both requests high
        repeat (3) tick();
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
        check("reset mem_rd", 32'(bus.mem_rd), 32'd0);
        winners.delete();
        reset = 1'b1;
        wait_gnt(1'b0, "first cpu");
        wait_gnt(1'b1, "first chk");
        settle();
        check("first winner is cpu", 32'(winners.size() > 0 ? winners[0] : 1'b1), 32'd0);

        // CPU read latency with known data
        cpu_issue(1'b1, 7'h05, 32'hDEAD_BEEF);
        wait_gnt(1'b0, "wr 05");
        settle();
        cpu_issue(1'b0, 7'h05, 32'h0);
        n = cyc;
        wait_gnt(1'b0, "rd 05");
        settle();
        check("rd05 gnt latency", 32'(cpu_gnt_cyc - n), 32'd1);
        check("rd05 mem_addr", 32'(cpu_gnt_addr), 32'h05);
        check("rd05 mem_rd", 32'(cpu_gnt_rd), 32'd1);
        check("rd05 rvalid latency", 32'(cpu_rv_cyc - n), 32'd3);
        check("rd05 rdata", last_cpu_rd, 32'hDEAD_BEEF);

        // Simultaneous requests after reset
        reset_pulse();
        tick();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'h10;
        bus.chk_req = 1'b1; bus.chk_addr = 7'h11;
        n = cyc;
        wait_gnt(1'b0, "conflict cpu");
        wait_gnt(1'b1, "conflict chk");
        settle();
        check("conflict cpu_gnt", 32'(cpu_gnt_cyc - n), 32'd1);
        check("conflict cpu_rvalid", 32'(cpu_rv_cyc - n), 32'd3);
        check("conflict chk_gnt", 32'(chk_gnt_cyc - n), 32'd4);
        check("conflict chk_rvalid", 32'(chk_rv_cyc - n), 32'd6);

        // CPU write then checker read of the same word
        wp = wr_pulses;
        rc = cpu_rv_count;
        cpu_issue(1'b1, 7'h20, 32'h1234_5678);
        wait_gnt(1'b0, "wr 20");
        tick();
        bus.chk_req = 1'b1; bus.chk_addr = 7'h20;
        wait_gnt(1'b1, "chk rd 20");
        settle();
        check("wr20 write pulses", 32'(wr_pulses - wp), 32'd1);
        check("wr20 no cpu_rvalid", 32'(cpu_rv_count - rc), 32'd0);
        check("wr20 chk_rdata", last_chk_rd, 32'h1234_5678);

        // Continuous load on both ports
        reset_pulse();
        winners.delete();
        tick();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 7'($urandom);
        bus.chk_req = 1'b1; bus.chk_addr = 7'($urandom);
        got = 0;
        for (int i = 0; i < 60 && got < 6; i++) begin
            tick();
            if (bus.cpu_gnt) begin got++; bus.cpu_addr = 7'($urandom); end
            if (bus.chk_gnt) begin got++; bus.chk_addr = 7'($urandom); end
        end
        bus.cpu_req = 1'b0;
        bus.chk_req = 1'b0;
        settle();
`ifdef DM_ARB_CPU_PRIO_EN
        exp_order = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        check("continuous grant count", 32'(winners.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("continuous winner %0d", i),
                  32'(i < winners.size() ? winners[i] : ~exp_order[i]), 32'(exp_order[i]));
        end

        // Reset in the middle of a CPU read
        rc = cpu_rv_count;
        cpu_issue(1'b0, 7'h05, 32'h0);
        wait_gnt(1'b0, "abort rd");
        tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        settle();
        check("abort no cpu_rvalid", 32'(cpu_rv_count - rc), 32'd0);
        cpu_issue(1'b0, 7'h05, 32'h0);
        n = cyc;
        wait_gnt(1'b0, "post-abort rd");
        settle();
        check("post-abort rvalid latency", 32'(cpu_rv_cyc - n), 32'd3);
        check("post-abort rdata", last_cpu_rd, 32'hDEAD_BEEF);

        // Randomized traffic; addresses biased to a small window to force RAW hazards
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (c == 700) begin
                bus.cpu_req = 1'b0;
                bus.chk_req = 1'b0;
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            if (bus.cpu_req && bus.cpu_gnt) bus.cpu_req = 1'b0;
            if (bus.chk_req && bus.chk_gnt) bus.chk_req = 1'b0;
            if (!bus.cpu_req && $urandom_range(0, 2) == 0) begin
                bus.cpu_req   = 1'b1;
                bus.cpu_we    = 1'($urandom_range(0, 1));
                bus.cpu_addr  = ($urandom_range(0, 3) == 0) ? 7'($urandom)
                                                             : 7'($urandom_range(0, 7));
                bus.cpu_wdata = $urandom;
            end
            if (!bus.chk_req && $urandom_range(0, 2) == 0) begin
                bus.chk_req  = 1'b1;
                bus.chk_addr = ($urandom_range(0, 3) == 0) ? 7'($urandom)
                                                            : 7'($urandom_range(0, 7));
            end
        end
        bus.cpu_req = 1'b0;
        bus.chk_req = 1'b0;
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish, expected completion before 1ms");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end
endmodule
